pit_table: RTL

PIT_TABLE -- requirements
Module: pit_table

---
 rtl/pit_pkg.sv | 25 ++
 rtl/pit_cam.sv | 96 +++++++++
 rtl/pit_table.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared types and constants for the pending-interest table.
package pit_pkg;

  localparam int unsigned PREFIX_W      = 64;
  localparam int unsigned LEN_W         = 6;
  localparam int unsigned BYTES_PER_PKT = 1024;
  localparam int unsigned CNT_W         = $clog2(BYTES_PER_PKT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_PKT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIntLookup,
    StFwd,
    StDataLookup,
    StXfer
  } pit_state_e;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } pit_entry_t;

endpackage

// File: rtl/pit_cam.sv
// Slot storage with combinational match, lowest-free-slot search and full flag.
// With PIT_TIMEOUT_EN defined each slot also ages out after TIMEOUT_CYCLES.
module pit_cam
  import pit_pkg::*;
#(
  parameter  int unsigned ENTRIES        = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned IDX_W          = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREFIX_W-1:0] i_key_prefix,
  input  logic [LEN_W-1:0]    i_key_len,
  input  logic                i_wr,
  input  logic                i_clr,
  input  logic [IDX_W-1:0]    i_idx,
`ifdef PIT_TIMEOUT_EN
  input  logic                i_xfer,
`endif
  output logic                o_hit,
  output logic [IDX_W-1:0]    o_hit_idx,
  output logic                o_full
);

  pit_entry_t         r_slots [ENTRIES];
  logic [IDX_W-1:0]   w_free_idx;
  logic [ENTRIES-1:0] w_kill;

  // Scan downwards so the lowest matching / free index is the one left standing.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    w_free_idx = '0;
    o_full     = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_slots[i].valid && r_slots[i].len == i_key_len &&
          r_slots[i].prefix == i_key_prefix) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
      if (!r_slots[i].valid) begin
        o_full     = 1'b0;
        w_free_idx = IDX_W'(i);
      end
    end
  end

`ifdef PIT_TIMEOUT_EN
  localparam int unsigned      AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

  logic [AGE_W-1:0] r_age [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_wr && w_free_idx == IDX_W'(i)) begin
          r_age[i] <= '0;
        end else if (r_slots[i].valid && r_age[i] != AGE_MAX) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

  // The slot being streamed is protected from expiry until its transfer completes.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_kill[i] = (i_clr && i_idx == IDX_W'(i)) ||
                  (r_slots[i].valid && r_age[i] == AGE_MAX &&
                   !(i_xfer && i_idx == IDX_W'(i)));
    end
  end
`else
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) w_kill[i] = i_clr && i_idx == IDX_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_slots[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_wr && w_free_idx == IDX_W'(i)) begin
          r_slots[i] <= '{valid: 1'b1, prefix: i_key_prefix, len: i_key_len};
        end else if (w_kill[i]) begin
          r_slots[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pit_table.sv
// Pending-interest table: aggregates/forwards interests and streams payload for matched names.
// Optional slot ageing is enabled by defining PIT_TIMEOUT_EN.
module pit_table
  import pit_pkg::*;
#(
  parameter int unsigned ENTRIES        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interest_valid,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  output logic                interest_ready,
  output logic                fib_out_bit,
  output logic [PREFIX_W-1:0] pit_in_prefix,
  output logic [LEN_W-1:0]    pit_in_len,
  input  logic                prefix_ready,
  input  logic [PREFIX_W-1:0] fib_prefix,
  input  logic [LEN_W-1:0]    fib_len,
  output logic                start_send_to_pit,
  output logic                rejected,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_out_valid,
  output logic                data_out_last,
  output logic                interest_drop
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  pit_state_e          r_state, w_state_next;
  logic [PREFIX_W-1:0] r_key_prefix, r_pit_prefix;
  logic [LEN_W-1:0]    r_key_len, r_pit_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_xfer_idx;
  logic [7:0]          r_data_out;
  logic                r_dvalid, r_dlast;
  logic                w_hit, w_full, w_wr, w_clr, w_cnt_last;
  logic [IDX_W-1:0]    w_hit_idx;

  assign w_cnt_last     = (r_cnt == CNT_LAST);
  assign pit_in_prefix  = r_pit_prefix;
  assign pit_in_len     = r_pit_len;
  assign data_out       = r_data_out;
  assign data_out_valid = r_dvalid;
  assign data_out_last  = r_dlast;

  pit_cam #(
    .ENTRIES        (ENTRIES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cam (
    .clk          (clk),
    .rst          (rst),
    .i_key_prefix (r_key_prefix),
    .i_key_len    (r_key_len),
    .i_wr         (w_wr),
    .i_clr        (w_clr),
    .i_idx        (r_xfer_idx),
`ifdef PIT_TIMEOUT_EN
    .i_xfer       (r_state == StXfer),
`endif
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx),
    .o_full       (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (prefix_ready)        w_state_next = StDataLookup;
        else if (interest_valid) w_state_next = StIntLookup;
      end
      StIntLookup:  w_state_next = (!w_hit && !w_full) ? StFwd : StIdle;
      StFwd:        w_state_next = StIdle;
      StDataLookup: w_state_next = w_hit ? StXfer : StIdle;
      StXfer:       if (w_cnt_last) w_state_next = StIdle;
      default:      w_state_next = StIdle;
    endcase
  end

  // Ready is masked by reset so every output reads 0 while rst is held low.
  always_comb begin
    interest_ready    = 1'b0;
    fib_out_bit       = 1'b0;
    start_send_to_pit = 1'b0;
    rejected          = 1'b0;
    interest_drop     = 1'b0;
    w_wr              = 1'b0;
    w_clr             = 1'b0;
    unique case (r_state)
      StIdle:       interest_ready = rst;
      StIntLookup: begin
        w_wr          = !w_hit && !w_full;
        interest_drop = !w_hit && w_full;
      end
      StFwd:        fib_out_bit = 1'b1;
      StDataLookup: begin
        start_send_to_pit = w_hit;
        rejected          = !w_hit;
      end
      StXfer:       w_clr = w_cnt_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_prefix <= '0;
      r_key_len    <= '0;
      r_pit_prefix <= '0;
      r_pit_len    <= '0;
      r_cnt        <= '0;
      r_xfer_idx   <= '0;
      r_data_out   <= '0;
      r_dvalid     <= 1'b0;
      r_dlast      <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (prefix_ready) begin
            r_key_prefix <= fib_prefix;
            r_key_len    <= fib_len;
          end else if (interest_valid) begin
            r_key_prefix <= interest_prefix;
            r_key_len    <= interest_len;
          end
        end
        StIntLookup: begin
          if (w_wr) begin
            r_pit_prefix <= r_key_prefix;
            r_pit_len    <= r_key_len;
          end
        end
        StDataLookup: begin
          r_cnt      <= '0;
          r_xfer_idx <= w_hit_idx;
        end
        StXfer: begin
          r_cnt      <= r_cnt + CNT_W'(1);
          r_data_out <= data_in;
          r_dvalid   <= 1'b1;
          r_dlast    <= w_cnt_last;
        end
        default: ;
      endcase
    end
  end

endmodule
